// File: rtl/add_requester.sv
// rtl/add_requester.sv - initiator-side controller for a registered adder handshake
//
// Accepts operand pairs from an upstream valid/ready stream and issues each
// pair to one external adder as a single-cycle doa pulse. The returned sum is
// buffered in a 2-entry FIFO for downstream. An adder that never answers is
// abandoned after TIMEOUT cycles in WAIT, and the sticky err flag is raised.
//
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   in_valid/in_ready    upstream operand handshake; in_a, in_b operands
//   a_in, b_in, doa      request to the adder (operands held until next accept)
//   done, result_out     adder response (result_out is N+1 bits, carry kept)
//   out_valid/out_ready  downstream handshake; out_sum is the FIFO head
//   err, clear_err       sticky timeout flag and its clear
module add_requester #(
  parameter int N       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] a_in,
  output logic [N-1:0] b_in,
  output logic         doa,
  input  logic         done,
  input  logic [N:0]   result_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out_sum,
  output logic         err,
  input  logic         clear_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ST} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] tcount;
  logic [N:0]    fifo_mem [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    fifo_count;
  logic          accept, push, pop, timeout_hit;

  // Accepting only when a FIFO slot is free reserves space for the result,
  // so a push can never meet a full FIFO.
  assign in_ready    = (state == IDLE) && (fifo_count < 2'd2);
  assign accept      = in_valid & in_ready;
  assign push        = (state == WAIT_ST) && done;
  assign timeout_hit = (state == WAIT_ST) && !done && (tcount == CW'(TIMEOUT - 1));
  assign out_valid   = (fifo_count != 2'd0);
  assign pop         = out_valid & out_ready;
  assign out_sum     = fifo_mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    doa       = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE: begin
        doa       = 1'b1;
        state_nxt = WAIT_ST;
      end
      WAIT_ST: if (done || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Zeroed in ISSUE so it reads 0 on the first WAIT cycle.
  always_ff @(posedge clk) begin
    if (!reset)                          tcount <= '0;
    else if (state == ISSUE)             tcount <= '0;
    else if (state == WAIT_ST && !done)  tcount <= tcount + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_in <= '0;
      b_in <= '0;
    end else if (accept) begin
      a_in <= in_a;
      b_in <= in_b;
    end
  end

  // Setting wins over clearing when both land on the same edge.
  always_ff @(posedge clk) begin
    if (!reset)           err <= 1'b0;
    else if (timeout_hit) err <= 1'b1;
    else if (clear_err)   err <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= result_out;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_add_requester.sv
// tb/tb_add_requester.sv - self-checking bench for add_requester
module tb_add_requester;
  localparam int N = 8;
  localparam int TIMEOUT = 15;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_a = '0, in_b = '0;
  logic [N-1:0] a_in, b_in;
  logic         doa;
  logic         done;
  logic [N:0]   result_out;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N:0]   out_sum;
  logic         err;
  logic         clear_err = 1'b0;

  // adder stub: mode 1 answers one cycle after doa, mode 0 never answers
  logic         stub_mode = 1'b1;
  logic         done_r = 1'b0;
  logic [N:0]   result_r = '0;
  logic         force_done = 1'b0;
  logic [N:0]   force_val = '0;

  int checks = 0;
  int failures = 0;
  int doa_count = 0;
  logic [N:0] got [$];

  // model state
  bit         m_live = 0;
  bit         m_busy = 0;
  int         m_phase = 0;
  bit         m_err = 0;
  bit         m_acc = 0;
  bit         m_to = 0;
  logic [N-1:0] m_a = '0, m_b = '0;
  logic [N:0] m_q [$];

  add_requester #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .a_in(a_in), .b_in(b_in), .doa(doa),
    .done(done), .result_out(result_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .err(err), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    done_r   <= stub_mode && doa;
    result_r <= {1'b0, a_in} + {1'b0, b_in};
  end
  assign done       = force_done | done_r;
  assign result_out = force_done ? force_val : result_r;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: one request in flight, counted in cycles since its accept edge
  // (0 = issue cycle, 1..TIMEOUT = wait cycles); results kept in a queue.
  always @(posedge clk) begin
    if (out_valid && out_ready && reset) got.push_back(out_sum);
    if (doa && reset) doa_count++;
    if (!reset) begin
      m_live = 1; m_busy = 0; m_phase = 0; m_err = 0; m_a = '0; m_b = '0;
      m_q.delete();
    end else if (m_live) begin
      m_acc = !m_busy && m_q.size() < 2 && in_valid;
      m_to = 0;
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (m_busy) begin
        if (m_phase == 0) m_phase = 1;
        else if (done) begin m_q.push_back(result_out); m_busy = 0; end
        else if (m_phase == TIMEOUT) begin m_to = 1; m_busy = 0; end
        else m_phase++;
      end
      if (m_to) m_err = 1;
      else if (clear_err) m_err = 0;
      if (m_acc) begin m_busy = 1; m_phase = 0; m_a = in_a; m_b = in_b; end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model_in_ready", {31'd0, in_ready}, {31'd0, !m_busy && m_q.size() < 2});
      check("model_doa", {31'd0, doa}, {31'd0, m_busy && m_phase == 0});
      check("model_out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
      check("model_err", {31'd0, err}, {31'd0, m_err});
      check("model_a_in", {24'd0, a_in}, {24'd0, m_a});
      check("model_b_in", {24'd0, b_in}, {24'd0, m_b});
      if (m_q.size() > 0) check("model_out_sum", {23'd0, out_sum}, {23'd0, m_q[0]});
    end
  end

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    check("send_accept_timely", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    int d0;
    // reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_doa", {31'd0, doa}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_a_in", {24'd0, a_in}, 32'd0);
    check("rst_b_in", {24'd0, b_in}, 32'd0);
    check("rst_out_sum", {23'd0, out_sum}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // single add 200+100
    out_ready = 1'b1; stub_mode = 1'b1; got.delete();
    d0 = doa_count;
    send(8'd200, 8'd100);
    @(posedge clk); #1;
    check("single_e1_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("single_e2_out_valid", {31'd0, out_valid}, 32'd1);
    check("single_sum", {23'd0, out_sum}, 32'd300);
    check("single_doa_pulses", doa_count - d0, 32'd1);
    @(posedge clk); #1;
    check("single_empty", {31'd0, out_valid}, 32'd0);

    // back-pressure
    out_ready = 1'b0; got.delete();
    send(8'd1, 8'd2);
    send(8'd3, 8'd4);
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd6;
    repeat (6) @(posedge clk);
    #1;
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_head", {23'd0, out_sum}, 32'd3);
    check("bp_nothing_popped", got.size(), 32'd0);
    out_ready = 1'b1;
    send(8'd5, 8'd6);
    repeat (6) @(posedge clk);
    #1;
    check("bp_drain_count", got.size(), 32'd3);
    if (got.size() == 3) begin
      check("bp_drain0", {23'd0, got[0]}, 32'd3);
      check("bp_drain1", {23'd0, got[1]}, 32'd7);
      check("bp_drain2", {23'd0, got[2]}, 32'd11);
    end

    // timeout
    stub_mode = 1'b0; got.delete();
    d0 = doa_count;
    send(8'd9, 8'd9);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (in_ready) break;
    end
    check("to_edges_to_idle", n, 32'd16);
    check("to_err", {31'd0, err}, 32'd1);
    check("to_no_push", {31'd0, out_valid}, 32'd0);
    check("to_doa_pulses", doa_count - d0, 32'd1);
    force_done = 1'b1; force_val = 9'd5;
    @(posedge clk); #1;
    force_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("to_late_done_ignored", {31'd0, out_valid}, 32'd0);
    check("to_late_nothing_popped", got.size(), 32'd0);
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    check("to_clear_err", {31'd0, err}, 32'd0);

    // reset while the adder answers in WAIT
    send(8'd10, 8'd20);
    @(posedge clk); #1;
    reset = 1'b0; force_done = 1'b1; force_val = 9'd42;
    @(posedge clk); #1;
    reset = 1'b1; force_done = 1'b0;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_a_in", {24'd0, a_in}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_still_empty", {31'd0, out_valid}, 32'd0);
    check("midrst_no_pop", got.size(), 32'd0);

    // simultaneous push and pop
    stub_mode = 1'b1; out_ready = 1'b0;
    send(8'd4, 8'd5);
    repeat (3) @(posedge clk);
    #1;
    got.delete();
    send(8'd6, 8'd7);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("pp_out_valid", {31'd0, out_valid}, 32'd1);
    check("pp_new_head", {23'd0, out_sum}, 32'd13);
    check("pp_pop_count", got.size(), 32'd1);
    if (got.size() >= 1) check("pp_first_pop", {23'd0, got[0]}, 32'd9);
    @(posedge clk); #1;
    check("pp_empty_after", {31'd0, out_valid}, 32'd0);
    check("pp_pop_count2", got.size(), 32'd2);
    if (got.size() >= 2) check("pp_second_pop", {23'd0, got[1]}, 32'd13);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/add_requester.md
# add_requester

Initiator-side controller for the registered `adder` handshake (`doa` request, `done`/`result_out` response). It accepts operand pairs from an upstream valid/ready stream and issues each pair to one external `adder` instance as a single-cycle `doa` pulse. It captures the sum when `done` arrives and presents results downstream through a 2-entry FIFO. It sits between the systolic-array partial-sum logic and the shared adder, and it detects an adder that never responds.

## Interface
- `N`, 8: operand width; matches the connected adder's `N`.
- `TIMEOUT`, 15: maximum cycles spent in WAIT before abort; must be ≥ 2.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low; sampled on rising `clk`.
- `in_valid`  in  1  upstream operand pair valid.
- `in_ready`  out  1  requester can accept a pair this cycle.
- `in_a`, `in_b`  in  N  operands.
- `a_in`, `b_in`  out  N  operands driven to the adder; held stable from accept until the next accept.
- `doa`  out  1  add request to the adder; one-cycle pulse.
- `done`  in  1  adder completion.
- `result_out`  in  N+1  adder sum; valid while `done`=1.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream consumes the head.
- `out_sum`  out  N+1  FIFO head sum.
- `err`  out  1  sticky timeout flag.
- `clear_err`  in  1  clears `err`.

## Operation
- **FSM states:**
  - IDLE → ISSUE on accept (`in_valid & in_ready`); `in_a`/`in_b` are latched into `a_in`/`b_in`.
  - ISSUE → WAIT unconditionally; `doa`=1 only in ISSUE.
  - WAIT → IDLE when `done`=1; `result_out` is pushed into the FIFO.
  - WAIT → IDLE when the timeout counter reaches `TIMEOUT` without `done`; `err` is set and nothing is pushed.
- **`in_ready`:** equals `(state==IDLE) & (fifo_count<2)`. Every accepted pair therefore has a reserved FIFO slot, so a push never meets a full FIFO.
- **Timeout counter:**
  - Cleared on entry to WAIT; increments each WAIT cycle without `done`.
  - Aborts in the WAIT cycle where count==`TIMEOUT`-1 and `done`=0.
  - WAIT therefore lasts at most `TIMEOUT` cycles.
- **FIFO:**
  - 2 entries, N+1 bits wide; `out_sum` shows the head; `out_valid` = (count≠0).
  - Pop when `out_valid & out_ready`.
  - Push and pop on the same edge: count is unchanged and ordering is preserved.
- **Spurious or late `done`:** `done` in IDLE or ISSUE, including a late response after a timeout, is ignored and causes no push.
- **Arithmetic:** no computation. `result_out` is stored unmodified at N+1 bits, so carry-out is preserved.
- **`err`:** set on timeout and cleared by `clear_err`. Set has priority when both occur on the same edge.

## Timing
- **Reset** (`reset`=0 at an edge):
  - state=IDLE, fifo_count=0, timeout counter=0.
  - `doa`=0, `err`=0, `out_valid`=0; `in_ready`=1 from the next cycle.
  - `a_in`, `b_in` and `out_sum` reset to 0.
  - Reset mid-transaction drops the in-flight request and all buffered results; a `done` arriving after reset is ignored.
- **Latency with a compliant adder** (accept at edge E0):
  - `doa`=1 during cycle E0→E1.
  - The adder asserts `done` after E1.
  - The FIFO push happens at E2; `out_valid`=1 after E2.
  - Result: 2 cycles from accept to `out_valid` (empty FIFO).
- **Throughput:** one transaction per 3 cycles (IDLE, ISSUE, WAIT); `in_ready` is low in ISSUE and WAIT.
- **Output hold:** `out_sum` and `out_valid` are stable while `out_valid & !out_ready`.
- **Full FIFO:** `in_ready`=0 while 2 results are unread. It returns to 1 the cycle after a pop, provided state==IDLE.

## Test plan
- **Reset values:** hold `reset`=0 for 2 cycles → all outputs are 0 except `in_ready`, which is 1 after release.
- **Single add, N=8:** `in_a`=200, `in_b`=100 with `out_ready`=1 → one `doa` pulse; `out_valid`=1 exactly 2 edges after accept with `out_sum`=300 (9-bit); FIFO then empty.
- **Back-pressure:** 3 pairs (1+2, 3+4, 5+6) with `out_ready`=0 → two results buffered (3, 7); `in_ready`=0 and the third pair is not accepted; raising `out_ready` drains 3, 7, then 11 in order.
- **Timeout:** adder stub never asserts `done`, TIMEOUT=15 → `doa` pulses once; WAIT lasts 15 cycles; `err`=1; no push; `in_ready`=1; a late `done` with `result_out`=5 produces no output; `clear_err` returns `err` to 0.
- **Reset mid-operation:** `reset`=0 in the WAIT cycle while the stub asserts `done` with `result_out`=42 → no output; FIFO empty; state IDLE.
- **Simultaneous push/pop:** FIFO holds 1 entry and `out_ready`=1 on the push edge → head pops, new result becomes head, count stays 1, order correct.
